// File: rtl/spi_lcd_cmd_decoder.sv
// spi_lcd_cmd_decoder
// Turns the SPI receiver byte stream into ILI9341-style window commands
// (CASET/PASET), a memory-write start (RAMWR) and RGB565 pixel writes.
// It also tracks the current pixel coordinate inside the committed window.
//
// Byte handshake: a byte is accepted only on a cycle where i_spi_byte_valid
// is high and i_spi_cs_n is low; i_spi_dc is sampled on that same cycle.
// There is no back-pressure. o_sram_waddr_set_req and o_sram_write_req are
// single-cycle strobes. o_pixel_data/o_pixel_x/o_pixel_y are valid while
// o_sram_write_req is high and hold their values until the next pixel.
module spi_lcd_cmd_decoder #(
   parameter logic [15:0] DEFAULT_END_X = 16'd319,
   parameter logic [15:0] DEFAULT_END_Y = 16'd239
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [7:0]  i_spi_byte,
   input  logic        i_spi_byte_valid,
   input  logic        i_spi_dc,
   input  logic        i_spi_cs_n,
   output logic [15:0] o_start_x,
   output logic [15:0] o_end_x,
   output logic [15:0] o_start_y,
   output logic [15:0] o_end_y,
   output logic        o_sram_waddr_set_req,
   output logic        o_sram_write_req,
   output logic [15:0] o_pixel_data,
   output logic [15:0] o_pixel_x,
   output logic [15:0] o_pixel_y,
   output logic [2:0]  o_dbg_state
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CASET  = 3'd1,
      ST_PASET  = 3'd2,
      ST_RAMWR  = 3'd3,
      ST_IGNORE = 3'd4
   } state_t;

   state_t      state_q;
   logic [1:0]  param_cnt_q;
   logic [15:0] sc_q;
   logic [15:0] ec_q;
   logic        phase_lo_q;
   logic [7:0]  hi_q;
   logic [15:0] ptr_x_q;
   logic [15:0] ptr_y_q;
   logic [15:0] start_x_q, end_x_q, start_y_q, end_y_q;
   logic        waddr_set_q;
   logic        write_req_q;
   logic [15:0] pixel_data_q, pixel_x_q, pixel_y_q;

   logic        byte_cmd;
   logic        byte_data;
   logic [15:0] ec_d;
   logic        win_ok;
   logic [15:0] ptr_x_d;
   logic [15:0] ptr_y_d;

   // Qualify the strobe with chip select; dc splits command from data.
   assign byte_cmd  = i_spi_byte_valid & ~i_spi_cs_n & ~i_spi_dc;
   assign byte_data = i_spi_byte_valid & ~i_spi_cs_n &  i_spi_dc;

   // End coordinate as it will be once the last parameter byte lands.
   assign ec_d   = {ec_q[15:8], i_spi_byte};
   assign win_ok = (sc_q <= ec_d);

   // Raster-order successor of the current pointer inside the window.
   always_comb begin
      ptr_x_d = ptr_x_q + 16'd1;
      ptr_y_d = ptr_y_q;
      if (ptr_x_q == end_x_q) begin
         ptr_x_d = start_x_q;
         ptr_y_d = (ptr_y_q == end_y_q) ? start_y_q : (ptr_y_q + 16'd1);
      end
   end

   // Command FSM, parameter shadowing, pixel assembly and pointer tracking.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= ST_IDLE;
         param_cnt_q  <= 2'd0;
         sc_q         <= 16'd0;
         ec_q         <= 16'd0;
         phase_lo_q   <= 1'b0;
         hi_q         <= 8'd0;
         ptr_x_q      <= 16'd0;
         ptr_y_q      <= 16'd0;
         start_x_q    <= 16'd0;
         end_x_q      <= DEFAULT_END_X;
         start_y_q    <= 16'd0;
         end_y_q      <= DEFAULT_END_Y;
         waddr_set_q  <= 1'b0;
         write_req_q  <= 1'b0;
         pixel_data_q <= 16'd0;
         pixel_x_q    <= 16'd0;
         pixel_y_q    <= 16'd0;
      end else begin
         waddr_set_q <= 1'b0;
         write_req_q <= 1'b0;

         // The pointer moves on the cycle the write pulse is visible.
         if (write_req_q) begin
            ptr_x_q <= ptr_x_d;
            ptr_y_q <= ptr_y_d;
         end

         if (i_spi_cs_n) begin
            // Abort: drop any partial parameter set or half pixel.
            state_q     <= ST_IDLE;
            param_cnt_q <= 2'd0;
            phase_lo_q  <= 1'b0;
         end else if (byte_cmd) begin
            param_cnt_q <= 2'd0;
            phase_lo_q  <= 1'b0;
            case (i_spi_byte)
               8'h2A: state_q <= ST_CASET;
               8'h2B: state_q <= ST_PASET;
               8'h2C: begin
                  state_q     <= ST_RAMWR;
                  waddr_set_q <= 1'b1;
                  ptr_x_q     <= start_x_q;
                  ptr_y_q     <= start_y_q;
               end
               8'h00:   state_q <= ST_IDLE;
               default: state_q <= ST_IGNORE;
            endcase
         end else if (byte_data) begin
            case (state_q)
               ST_CASET, ST_PASET: begin
                  param_cnt_q <= param_cnt_q + 2'd1;
                  case (param_cnt_q)
                     2'd0: sc_q[15:8] <= i_spi_byte;
                     2'd1: sc_q[7:0]  <= i_spi_byte;
                     2'd2: ec_q[15:8] <= i_spi_byte;
                     default: begin
                        ec_q[7:0] <= i_spi_byte;
                        if (win_ok) begin
                           if (state_q == ST_CASET) begin
                              start_x_q <= sc_q;
                              end_x_q   <= ec_d;
                           end else begin
                              start_y_q <= sc_q;
                              end_y_q   <= ec_d;
                           end
                        end
                        state_q <= ST_IDLE;
                     end
                  endcase
               end
               ST_RAMWR: begin
                  if (!phase_lo_q) begin
                     hi_q       <= i_spi_byte;
                     phase_lo_q <= 1'b1;
                  end else begin
                     pixel_data_q <= {hi_q, i_spi_byte};
                     pixel_x_q    <= ptr_x_q;
                     pixel_y_q    <= ptr_y_q;
                     write_req_q  <= 1'b1;
                     phase_lo_q   <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign o_start_x            = start_x_q;
   assign o_end_x              = end_x_q;
   assign o_start_y            = start_y_q;
   assign o_end_y              = end_y_q;
   assign o_sram_waddr_set_req = waddr_set_q;
   assign o_sram_write_req     = write_req_q;
   assign o_pixel_data         = pixel_data_q;
   assign o_pixel_x            = pixel_x_q;
   assign o_pixel_y            = pixel_y_q;
   assign o_dbg_state          = state_q;

endmodule

// File: tb/tb_spi_lcd_cmd_decoder.sv
// Bench for spi_lcd_cmd_decoder: a transaction-level model predicts the
// outputs after every accepted byte; a compare process checks every cycle.
module tb_spi_lcd_cmd_decoder;

   logic        clk;
   logic        rst_n;
   logic [7:0]  spi_byte;
   logic        spi_valid;
   logic        spi_dc;
   logic        spi_cs_n;
   logic [15:0] start_x, end_x, start_y, end_y;
   logic        waddr_set_req, write_req;
   logic [15:0] pixel_data, pixel_x, pixel_y;
   logic [2:0]  dbg_state;

   spi_lcd_cmd_decoder dut (
      .i_clk                (clk),
      .i_rst_n              (rst_n),
      .i_spi_byte           (spi_byte),
      .i_spi_byte_valid     (spi_valid),
      .i_spi_dc             (spi_dc),
      .i_spi_cs_n           (spi_cs_n),
      .o_start_x            (start_x),
      .o_end_x              (end_x),
      .o_start_y            (start_y),
      .o_end_y              (end_y),
      .o_sram_waddr_set_req (waddr_set_req),
      .o_sram_write_req     (write_req),
      .o_pixel_data         (pixel_data),
      .o_pixel_x            (pixel_x),
      .o_pixel_y            (pixel_y),
      .o_dbg_state          (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- counters ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   // Mode codes: 0 idle, 1 caset, 2 paset, 3 ramwr, 4 ignore.
   int          m_mode;
   int          m_cnt;
   logic [7:0]  m_p [4];
   bit          m_lo;
   logic [7:0]  m_hi;
   logic [15:0] m_px, m_py;
   logic [15:0] exp_sx, exp_ex, exp_sy, exp_ey;
   logic [15:0] exp_pd, exp_px, exp_py;
   bit          exp_wr, exp_ws;

   task automatic model_reset();
      m_mode = 0; m_cnt = 0; m_lo = 0; m_hi = 0; m_px = 0; m_py = 0;
      exp_sx = 0; exp_ex = 16'd319; exp_sy = 0; exp_ey = 16'd239;
      exp_pd = 0; exp_px = 0; exp_py = 0; exp_wr = 0; exp_ws = 0;
   endtask

   task automatic model_byte(input bit dc, input logic [7:0] b);
      logic [15:0] sc, ec;
      if (!dc) begin
         m_cnt = 0;
         m_lo  = 0;
         case (b)
            8'h2A: m_mode = 1;
            8'h2B: m_mode = 2;
            8'h2C: begin m_mode = 3; exp_ws = 1; m_px = exp_sx; m_py = exp_sy; end
            8'h00: m_mode = 0;
            default: m_mode = 4;
         endcase
      end else if (m_mode == 1 || m_mode == 2) begin
         m_p[m_cnt] = b;
         m_cnt++;
         if (m_cnt == 4) begin
            sc = {m_p[0], m_p[1]};
            ec = {m_p[2], m_p[3]};
            if (sc <= ec) begin
               if (m_mode == 1) begin exp_sx = sc; exp_ex = ec; end
               else             begin exp_sy = sc; exp_ey = ec; end
            end
            m_mode = 0;
            m_cnt  = 0;
         end
      end else if (m_mode == 3) begin
         if (!m_lo) begin
            m_hi = b;
            m_lo = 1;
         end else begin
            exp_pd = {m_hi, b};
            exp_px = m_px;
            exp_py = m_py;
            exp_wr = 1;
            m_lo   = 0;
            if (m_px == exp_ex) begin
               m_px = exp_sx;
               m_py = (m_py == exp_ey) ? exp_sy : m_py + 16'd1;
            end else begin
               m_px = m_px + 16'd1;
            end
         end
      end
   endtask

   task automatic model_abort();
      m_mode = 0; m_cnt = 0; m_lo = 0;
   endtask

   // ---------------- scoreboard / compare ----------------
   bit          chk_en = 0;
   int          wr_cnt = 0;
   int          ws_cnt = 0;
   logic [15:0] obs_x[$];
   logic [15:0] obs_y[$];
   logic [15:0] obs_d[$];

   always begin
      @(posedge clk);
      #1;
      if (chk_en) begin
         chk("start_x", start_x, exp_sx);
         chk("end_x", end_x, exp_ex);
         chk("start_y", start_y, exp_sy);
         chk("end_y", end_y, exp_ey);
         chk("waddr_set_req", waddr_set_req, exp_ws);
         chk("write_req", write_req, exp_wr);
         chk("pixel_data", pixel_data, exp_pd);
         chk("pixel_x", pixel_x, exp_px);
         chk("pixel_y", pixel_y, exp_py);
         if (write_req) begin
            wr_cnt++;
            obs_x.push_back(pixel_x);
            obs_y.push_back(pixel_y);
            obs_d.push_back(pixel_data);
         end
         if (waddr_set_req) ws_cnt++;
         exp_wr = 0;
         exp_ws = 0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input bit dc, input logic [7:0] b);
      @(negedge clk);
      spi_dc = dc; spi_byte = b; spi_valid = 1'b1;
      model_byte(dc, b);
      @(negedge clk);
      spi_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic send_pixel(input logic [15:0] v);
      send(1'b1, v[15:8]);
      send(1'b1, v[7:0]);
   endtask

   // cs_n high for one cycle with a data strobe that must be ignored.
   task automatic abort_cs();
      @(negedge clk);
      spi_cs_n = 1'b1; spi_dc = 1'b1; spi_byte = 8'h55; spi_valid = 1'b1;
      model_abort();
      @(negedge clk);
      spi_cs_n = 1'b0; spi_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic check_reset_literals(input string tag);
      chk({tag, "_start_x"}, start_x, 16'd0);
      chk({tag, "_end_x"}, end_x, 16'd319);
      chk({tag, "_start_y"}, start_y, 16'd0);
      chk({tag, "_end_y"}, end_y, 16'd239);
      chk({tag, "_pulses"}, {waddr_set_req, write_req}, 2'b00);
      chk({tag, "_pixel"}, {pixel_data, pixel_x}, 32'd0);
      chk({tag, "_pixel_y"}, pixel_y, 16'd0);
      chk({tag, "_state"}, dbg_state, 3'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int ab_cnt;
      rst_n = 1'b0; spi_byte = 8'h00; spi_valid = 1'b0; spi_dc = 1'b0; spi_cs_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      check_reset_literals("reset");
      @(negedge clk);
      rst_n = 1'b1;
      chk_en = 1;
      repeat (2) @(negedge clk);

      // Window x 10..19, y 5..6.
      send(0, 8'h2A); send(1, 8'h00); send(1, 8'h0A); send(1, 8'h00); send(1, 8'h13);
      send(0, 8'h2B); send(1, 8'h00); send(1, 8'h05); send(1, 8'h00); send(1, 8'h06);
      chk("win_sx", start_x, 16'd10);
      chk("win_ex", end_x, 16'd19);
      chk("win_sy", start_y, 16'd5);
      chk("win_ey", end_y, 16'd6);
      send(1, 8'h99);  // data in IDLE is ignored

      // One RAMWR, 20 pixels fill the window exactly.
      send(0, 8'h2C);
      for (int i = 0; i < 20; i++) send_pixel(16'hF800 + 16'(i));
      chk("wr_cnt_20", wr_cnt, 20);
      chk("ws_cnt_1", ws_cnt, 1);
      chk("px0", {obs_x[0], obs_y[0]}, {16'd10, 16'd5});
      chk("pd0", obs_d[0], 16'hF800);
      chk("px9", {obs_x[9], obs_y[9]}, {16'd19, 16'd5});
      chk("px10", {obs_x[10], obs_y[10]}, {16'd10, 16'd6});
      chk("px19", {obs_x[19], obs_y[19]}, {16'd19, 16'd6});
      chk("pd19", obs_d[19], 16'hF813);

      // 21 more: wraps back to the window origin twice.
      for (int i = 0; i < 21; i++) send_pixel(16'hF814 + 16'(i));
      chk("wr_cnt_41", wr_cnt, 41);
      chk("px20", {obs_x[20], obs_y[20]}, {16'd10, 16'd5});
      chk("px39", {obs_x[39], obs_y[39]}, {16'd19, 16'd6});
      chk("px40", {obs_x[40], obs_y[40]}, {16'd10, 16'd5});
      chk("pd40", obs_d[40], 16'hF828);

      // SC > EC is rejected; a truncated CASET never commits.
      send(0, 8'h2A); send(1, 8'h00); send(1, 8'h20); send(1, 8'h00); send(1, 8'h10);
      send(0, 8'h2A); send(1, 8'h00); send(1, 8'h30);
      send(0, 8'h2B); send(0, 8'h00);
      chk("rej_sx", start_x, 16'd10);
      chk("rej_ex", end_x, 16'd19);

      // Unknown command: data is discarded.
      send(0, 8'h36); send(1, 8'h11); send(1, 8'h22);

      // Half pixel aborted by cs_n, data without RAMWR ignored, then fresh RAMWR.
      send(0, 8'h2C); send(1, 8'hAB);
      abort_cs();
      send(1, 8'h12); send(1, 8'h34);
      chk("no_pix_after_abort", wr_cnt, 41);
      chk("pd_held", pixel_data, 16'hF828);
      send(0, 8'h2C); send(1, 8'h12); send(1, 8'h34);
      chk("wr_cnt_42", wr_cnt, 42);
      chk("ws_cnt_3", ws_cnt, 3);
      chk("pd_1234", obs_d[41], 16'h1234);
      chk("px_1234", {obs_x[41], obs_y[41]}, {16'd10, 16'd5});
      ab_cnt = 0;
      foreach (obs_d[k]) if (obs_d[k][15:8] == 8'hAB || obs_d[k][7:0] == 8'hAB) ab_cnt++;
      chk("no_ab_pixel", ab_cnt, 0);

      // Asynchronous reset mid-pixel clears everything at once.
      send(0, 8'h2C); send(1, 8'h77);
      @(negedge clk);
      chk_en = 0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_reset_literals("async_rst");
      @(negedge clk);
      chk_en = 1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send(1, 8'h01);
      repeat (3) @(negedge clk);
      chk("wr_cnt_final", wr_cnt, 42);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_lcd_cmd_decoder.md
# spi_lcd_cmd_decoder

Decodes the byte stream from the SPI receiver into an ILI9341-style command set: column/page address windows (CASET/PASET), memory write start (RAMWR), and RGB565 pixel words. It sits directly upstream of the framebuffer FIFO writer. It supplies that stage's window coordinates, its write-address-set request, and one write request per assembled pixel. It also tracks the current pixel coordinate inside the window for the SRAM address path.

## Interface
- DEFAULT_END_X, 319, reset value of o_end_x
- DEFAULT_END_Y, 239, reset value of o_end_y
- i_clk  in  1  system clock; single clock domain
- i_rst_n  in  1  asynchronous, active-low reset
- i_spi_byte  in  8  received SPI byte, valid with i_spi_byte_valid
- i_spi_byte_valid  in  1  one-cycle strobe per received byte; upstream guarantees ≥2 idle cycles between strobes
- i_spi_dc  in  1  0 = command byte, 1 = data byte; sampled with the strobe
- i_spi_cs_n  in  1  chip select, synchronised upstream; high aborts the transaction in progress
- o_start_x, o_end_x, o_start_y, o_end_y  out  16 each  committed address window
- o_sram_waddr_set_req  out  1  one-cycle pulse on RAMWR
- o_sram_write_req  out  1  one-cycle pulse per completed pixel
- o_pixel_data  out  16  RGB565 pixel; held until the next pixel
- o_pixel_x, o_pixel_y  out  16 each  coordinate of the pixel in o_pixel_data

## Operation
- States: IDLE, CASET, PASET, RAMWR, IGNORE.
- Any command byte (dc=0), from any state, selects the next state:
  - 0x2A → CASET
  - 0x2B → PASET
  - 0x2C → RAMWR
  - 0x00 (NOP) → IDLE
  - anything else → IGNORE
- A command byte always resets the parameter byte counter (2 bits) and the pixel byte phase.
- CASET and PASET parameters:
  - Data bytes 0..3 load shadow registers in order: SC[15:8], SC[7:0], EC[15:8], EC[7:0].
  - On byte 3, the window commits to o_start_*/o_end_* only if SC ≤ EC. If SC > EC the committed window is unchanged.
  - After the commit the state goes to IDLE. Further data bytes in IDLE are ignored.
- A partial parameter set never commits. This applies when a new command arrives or cs_n rises before byte 3.
- RAMWR entry:
  - o_sram_waddr_set_req pulses.
  - Pointer loads to (o_start_x, o_start_y).
  - Byte phase is set to HI.
- RAMWR pixel stream:
  - HI data byte: latched in the high-byte register. Phase becomes LO.
  - LO data byte: o_pixel_data = {hi, byte} and o_sram_write_req pulses. o_pixel_x/o_pixel_y show the pre-advance pointer. Phase returns to HI.
- Pointer advance, on the cycle after each pixel pulse:
  - If x == end_x: x ← start_x, then y ← (y == end_y) ? start_y : y+1.
  - Otherwise x ← x+1.
  - All arithmetic is 16-bit unsigned.
- IGNORE: all data bytes are discarded.
- cs_n high:
  - State goes to IDLE. The byte phase and parameter counter clear, and a half pixel is discarded.
  - Committed window, pointer, and o_pixel_data are unchanged.
  - A strobe coinciding with cs_n high is ignored.
- After a RAMWR has been aborted by cs_n, a fresh RAMWR is needed before pixels are accepted.

## Timing
- Reset values:
  - o_start_x = o_start_y = 0
  - o_end_x = DEFAULT_END_X, o_end_y = DEFAULT_END_Y
  - o_pixel_data = 0, o_pixel_x = o_pixel_y = 0
  - o_sram_write_req = o_sram_waddr_set_req = 0
  - State IDLE
- All outputs are registered.
- CASET/PASET byte 3 strobe at cycle N → new window visible at N+1.
- RAMWR strobe at N → o_sram_waddr_set_req high during N+1 only. The window is stable across that pulse.
- LO byte strobe at N:
  - o_sram_write_req is high during N+1 only.
  - o_pixel_data, o_pixel_x and o_pixel_y are valid at N+1.
  - The pointer advances at N+2.
- The request pulses are never high on consecutive cycles, which keeps the downstream edge detector correct.
- Asynchronous reset mid-operation clears everything immediately. No pulse is emitted afterwards.

## Test plan
- Reset, then check all outputs: end_x = 319, end_y = 239, other outputs 0, no pulses.
- CASET 0x2A with data 00 0A 00 13, then PASET 0x2B with data 00 05 00 06 → window x 10..19, y 5..6. Each commit is visible 1 cycle after its last byte.
- RAMWR, then 20 pixel pairs 0xF800+i → 1 waddr_set pulse and 20 write pulses.
  - Coordinates: (10,5)…(19,5), then (10,6)…(19,6).
  - Pixel data matches each pair.
- Continuing with 21 more pixels after that → the pointer wraps to (10,5) after (19,6).
- CASET data 00 20 00 10 (SC > EC) → window unchanged. A CASET truncated after 2 bytes by a PASET command → no x change.
- Within RAMWR: HI byte 0xAB, then cs_n high, then RAMWR, then bytes 12 34 → exactly one pixel, 0x1234, at the start coordinate. No pixel contains 0xAB.
